// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD operand driver and its timeout counter:
//   - state_t    : driver FSM state encoding
//   - GCD_W_DEF  : default operand/result width
//   - GCD_TMO_DEF: default number of WAIT cycles before a job is aborted
// No ports (package).
// -----------------------------------------------------------------------------
package gcd_pkg;

    localparam int GCD_W_DEF   = 16;
    localparam int GCD_TMO_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD_A = 3'd2,
        LOAD_B = 3'd3,
        WAIT   = 3'd4,
        RESP   = 3'd5
    } state_t;

endpackage

// File: rtl/gcd_timeout_counter.sv
// -----------------------------------------------------------------------------
// gcd_timeout_counter
// Counts cycles while enabled and flags when the job has been waiting for
// TIMEOUT_CYC cycles. The count saturates at its last value and never wraps,
// so a stuck enable can never re-arm the flag by rolling over.
// Ports:
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset
//   clr      in  synchronous clear back to zero (wins over en)
//   en       in  count enable
//   expired  out high while the count sits at TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module gcd_timeout_counter
    import gcd_pkg::*;
#(
    parameter int TIMEOUT_CYC = GCD_TMO_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Saturating increment: holds at CNT_LAST instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_LAST) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign expired = (cnt == CNT_LAST);

endmodule

// File: rtl/gcd_operand_driver.sv
// -----------------------------------------------------------------------------
// gcd_operand_driver
// Host-side driver for the GCD engine. Accepts an operand pair, clears the
// engine, loads A (with the start strobe) then B over the shared load bus,
// waits for done, and presents the result until the consumer takes it.
// Zero operands are answered locally without touching the engine; a job that
// waits TIMEOUT_CYC cycles is aborted with an error and the engine is cleared.
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   op_valid, op_ready    operand handshake (op_ready high only in IDLE)
//   op_a, op_b            operand pair, registered on acceptance
//   eng_clr               one-cycle engine clear pulse
//   eng_data              shared load bus (zero outside LOAD_A/LOAD_B)
//   eng_start             start strobe, high together with operand A
//   eng_done, eng_result  engine completion level and result
//   res_valid, res_ready  result handshake
//   res_data, res_err     result value and error flag (0,0 operands or timeout)
//   busy                  high in any state other than IDLE
// -----------------------------------------------------------------------------
module gcd_operand_driver
    import gcd_pkg::*;
#(
    parameter int W           = GCD_W_DEF,
    parameter int TIMEOUT_CYC = GCD_TMO_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         eng_clr,
    output logic [W-1:0] eng_data,
    output logic         eng_start,
    input  logic         eng_done,
    input  logic [W-1:0] eng_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic         busy
);

    state_t       state;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         tmo_expired;

    // gcd(x,0) = gcd(0,x) = x; gcd(0,0) yields 0 and is flagged separately.
    function automatic logic [W-1:0] bypass_result(input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
        return (a == '0) ? b : a;
    endfunction

    // The counter is held at zero everywhere except WAIT, so it is always
    // fresh when LOAD_B hands over to WAIT.
    gcd_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != WAIT),
        .en      (state == WAIT),
        .expired (tmo_expired)
    );

    assign op_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            eng_clr   <= 1'b0;
            eng_start <= 1'b0;
            eng_data  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            // Engine strobes are single-cycle and the bus idles at zero;
            // each state below re-asserts only what the next state shows.
            eng_clr   <= 1'b0;
            eng_start <= 1'b0;
            eng_data  <= '0;

            case (state)
                IDLE: begin
                    if (op_valid) begin
                        a_q <= op_a;
                        b_q <= op_b;
                        if (op_a == '0 || op_b == '0) begin
                            state     <= RESP;
                            res_valid <= 1'b1;
                            res_data  <= bypass_result(op_a, op_b);
                            res_err   <= (op_a == '0) && (op_b == '0);
                        end else begin
                            state   <= CLEAR;
                            eng_clr <= 1'b1;
                        end
                    end
                end

                CLEAR: begin
                    state     <= LOAD_A;
                    eng_data  <= a_q;
                    eng_start <= 1'b1;
                end

                LOAD_A: begin
                    state    <= LOAD_B;
                    eng_data <= b_q;
                end

                LOAD_B: begin
                    state <= WAIT;
                end

                WAIT: begin
                    // done is checked first so it wins over a same-cycle timeout.
                    if (eng_done) begin
                        state     <= RESP;
                        res_valid <= 1'b1;
                        res_data  <= eng_result;
                        res_err   <= 1'b0;
                    end else if (tmo_expired) begin
                        state     <= RESP;
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        eng_clr   <= 1'b1;
                    end
                end

                RESP: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
